// File: rtl/player_input_conditioner.sv
// Tug-of-war front end: synchronizes, debounces and edge-detects two
// active-low player buttons into one-cycle move pulses L and R. A press
// accepted while freeze is high is consumed and never produces a pulse.

// One button channel: two-flop synchronizer, counter debouncer, and a
// combinational flag raised on the edge where a press is accepted.
module player_input_conditioner_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          s1_r;
  logic          s2_r;
  logic          st_r;
  logic [CW-1:0] cnt_r;

  logic          differ_s;
  logic          at_max_s;
  logic          accept_s;
  logic          st_next_s;
  logic [CW-1:0] cnt_next_s;

  // Two-flop synchronizer; reset value is "released" (high).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_r <= 1'b1;
      s2_r <= 1'b1;
    end else begin
      s1_r <= key;
      s2_r <= s1_r;
    end
  end

  // Debounce next-state: count consecutive cycles that differ from the
  // stable level; any return to the stable level discards the count.
  always_comb begin
    differ_s   = (s2_r != st_r);
    at_max_s   = (cnt_r == CNT_MAX);
    accept_s   = differ_s & at_max_s;
    st_next_s  = st_r;
    cnt_next_s = cnt_r;
    if (!differ_s) begin
      cnt_next_s = CNT_ZERO;
    end else if (at_max_s) begin
      st_next_s  = s2_r;
      cnt_next_s = CNT_ZERO;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
    end
  end

  // Debounce state register; the counter never passes CNT_MAX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_r  <= 1'b1;
      cnt_r <= CNT_ZERO;
    end else begin
      st_r  <= st_next_s;
      cnt_r <= cnt_next_s;
    end
  end

  // Press flag: an accept that moves the stable level from released to
  // pressed. Release acceptances never flag.
  always_comb begin
    if (accept_s && st_r) begin
      press = 1'b1;
    end else begin
      press = 1'b0;
    end
  end

endmodule

// Top level: two independent channels plus registered, freeze-masked
// move pulses and the tie indication.
module player_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic keyL,
  input  logic keyR,
  input  logic freeze,
  output logic L,
  output logic R,
  output logic tie
);

  logic press_l_s;
  logic press_r_s;
  logic move_l_s;
  logic move_r_s;

  player_input_conditioner_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CW             (CW)
  ) u_chan_l (
    .clk  (clk),
    .reset(reset),
    .key  (keyL),
    .press(press_l_s)
  );

  player_input_conditioner_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CW             (CW)
  ) u_chan_r (
    .clk  (clk),
    .reset(reset),
    .key  (keyR),
    .press(press_r_s)
  );

  // Freeze masks only the pulses; a press accepted while frozen is lost.
  always_comb begin
    if (freeze) begin
      move_l_s = 1'b0;
      move_r_s = 1'b0;
    end else begin
      move_l_s = press_l_s;
      move_r_s = press_r_s;
    end
  end

  // Registered outputs: one-cycle pulses and their coincidence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      L   <= 1'b0;
      R   <= 1'b0;
      tie <= 1'b0;
    end else begin
      L   <= move_l_s;
      R   <= move_r_s;
      tie <= move_l_s & move_r_s;
    end
  end

endmodule

// File: tb/tb_player_input_conditioner.sv
// Scoreboard bench for player_input_conditioner (DEBOUNCE_CYCLES = 4).
// Stimulus pushes the expected pulse (edge number and L/R/tie values);
// a negedge monitor pops and compares whenever any output is high.
module tb_player_input_conditioner;

  logic clk;
  logic reset;
  logic keyL;
  logic keyR;
  logic freeze;
  logic L;
  logic R;
  logic tie;

  typedef struct {
    int   cyc;
    logic l;
    logic r;
    logic t;
  } exp_t;

  exp_t exp_q[$];
  int   cycle_cnt;
  int   tests;
  int   fails;

  player_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .keyL  (keyL),
    .keyR  (keyR),
    .freeze(freeze),
    .L     (L),
    .R     (R),
    .tie   (tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts rising edges; at a negedge it holds the number of the last edge.
  initial cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Monitor: outputs must be 0 during reset; any pulse must match the
  // head of the expectation queue exactly.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      tests++;
      if (L || R || tie) begin
        fails++;
        $display("FAIL reset_outputs: got L=%0b R=%0b tie=%0b, want 0 0 0", L, R, tie);
      end
    end else if (L || R || tie) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse at edge %0d: got L=%0b R=%0b tie=%0b, want no pulse",
                 cycle_cnt, L, R, tie);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cycle_cnt || e.l != L || e.r != R || e.t != tie) begin
          fails++;
          $display("FAIL pulse: got edge %0d L=%0b R=%0b tie=%0b, want edge %0d L=%0b R=%0b tie=%0b",
                   cycle_cnt, L, R, tie, e.cyc, e.l, e.r, e.t);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Key driven at this negedge is first sampled at the next edge k;
  // the pulse is then visible after edge k+5.
  task automatic expect_pulse(input logic l, input logic r);
    exp_t e;
    e.cyc = cycle_cnt + 6;
    e.l   = l;
    e.r   = r;
    e.t   = l & r;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: got %0d pending pulses, want 0 (next expected edge %0d)",
               name, exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b0;
    keyL   = 1'b1;
    keyR   = 1'b1;
    freeze = 1'b0;
    step(3);
    reset = 1'b1;
    step(3);

    // 1: held left press -> one pulse, no repeat over 20 more cycles
    keyL = 1'b0;
    expect_pulse(1'b1, 1'b0);
    step(26);
    check_drained("held_left_single_pulse");
    keyL = 1'b1;
    step(10);

    // 2: right bounce never accepted, then a stable press pulses once
    keyR = 1'b0; step(2);
    keyR = 1'b1; step(1);
    keyR = 1'b0; step(1);
    keyR = 1'b1; step(8);
    check_drained("right_bounce_rejected");
    keyR = 1'b0;
    expect_pulse(1'b0, 1'b1);
    step(6);
    keyR = 1'b1;
    step(8);
    check_drained("right_stable_press");

    // 3: simultaneous presses -> L, R and tie together
    keyL = 1'b0;
    keyR = 1'b0;
    expect_pulse(1'b1, 1'b1);
    step(8);
    keyL = 1'b1;
    keyR = 1'b1;
    step(8);
    check_drained("tie_pulse");

    // 4: press accepted under freeze is consumed
    freeze = 1'b1;
    keyL   = 1'b0;
    step(10);
    freeze = 1'b0;
    step(6);
    check_drained("frozen_press_consumed");
    keyL = 1'b1;
    step(8);
    keyL = 1'b0;
    expect_pulse(1'b1, 1'b0);
    step(8);
    keyL = 1'b1;
    step(8);
    check_drained("press_after_unfreeze");

    // 5: reset mid-count discards the count; held key re-accepted after
    keyL = 1'b0;
    step(4);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    expect_pulse(1'b1, 1'b0);
    step(8);
    keyL = 1'b1;
    step(8);
    check_drained("reset_mid_count");

    // 6: press / release / press, 6 cycles each -> two pulses 12 apart
    keyL = 1'b0;
    expect_pulse(1'b1, 1'b0);
    step(6);
    keyL = 1'b1;
    step(6);
    keyL = 1'b0;
    expect_pulse(1'b1, 1'b0);
    step(6);
    keyL = 1'b1;
    step(8);
    check_drained("double_press");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
